// File: rtl/hazard_unit_p.sv
// rtl/hazard_unit_p.sv - pipeline hazard controller: stalls, flushes, forwarding, multi-cycle EX
module hazard_unit_p #(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic              id_branch,
    input  logic              id_multi,
    input  logic              branch_taken,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              fwd_a_d,
    output logic              fwd_b_d,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cycles
);

    // Multi-cycle countdown width; at least one bit so MUL_LAT=1 still elaborates.
    localparam int              CW       = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0]   LAT_LOAD = CW'(MUL_LAT - 1);

    // Shadow slots. Only the fields that some hazard or forwarding term reads
    // are kept: M and W never need their source indices or valid bit, since a
    // bubble already has reg_write/mem_to_reg cleared and dst zero.
    logic              e_valid;
    logic [REG_AW-1:0] e_rs;
    logic [REG_AW-1:0] e_rt;
    logic [REG_AW-1:0] e_dst;
    logic              e_rw;
    logic              e_m2r;

    logic [REG_AW-1:0] m_dst;
    logic              m_rw;
    logic              m_m2r;

    logic [REG_AW-1:0] w_dst;
    logic              w_rw;

    logic [CW-1:0]     cnt;

    logic              hit_e;
    logic              hit_m;
    logic              lu;
    logic              br;
    logic              stall;
    logic              enter_multi;

    // ID sources against the E and M destinations; register 0 never matches.
    assign hit_e = e_valid && (e_dst != '0) &&
                   ((id_uses_rs && (id_rs == e_dst)) || (id_uses_rt && (id_rt == e_dst)));
    assign hit_m = (m_dst != '0) &&
                   ((id_uses_rs && (id_rs == m_dst)) || (id_uses_rt && (id_rt == m_dst)));

    // Load in EX feeding ID costs one bubble.
    assign lu = id_valid && e_m2r && hit_e;

    // A branch compares in ID, so it must also wait for an ALU result in EX
    // and for a load result still in MEM (not forwardable to ID).
    assign br = id_valid && id_branch && ((hit_e && e_rw) || (hit_m && m_m2r));

    assign busy  = (cnt != '0);
    assign stall = lu || br || busy;

    assign stall_f = stall;
    assign stall_d = stall;
    assign stall_e = busy;

    // While busy, E is held rather than bubbled, so no flush into ID/EX.
    assign flush_e = (lu || br) && !busy;

    // A stalled branch is re-evaluated next cycle, so it must not redirect yet.
    assign flush_d = id_valid && id_branch && branch_taken && !stall;

    // ID comparator may take the MEM ALU result, never a MEM load result.
    assign fwd_a_d = m_rw && !m_m2r && (m_dst != '0) && (m_dst == id_rs);
    assign fwd_b_d = m_rw && !m_m2r && (m_dst != '0) && (m_dst == id_rt);

    // A multi-cycle op starts its countdown only when it actually enters E.
    assign enter_multi = !stall && id_valid && id_multi;

    // EX operand selects: MEM result wins over WB result.
    always_comb begin
        fwd_a_e = 2'b00;
        fwd_b_e = 2'b00;
        if (m_rw && (m_dst != '0) && (m_dst == e_rs)) begin
            fwd_a_e = 2'b10;
        end else if (w_rw && (w_dst != '0) && (w_dst == e_rs)) begin
            fwd_a_e = 2'b01;
        end
        if (m_rw && (m_dst != '0) && (m_dst == e_rt)) begin
            fwd_b_e = 2'b10;
        end else if (w_rw && (w_dst != '0) && (w_dst == e_rt)) begin
            fwd_b_e = 2'b01;
        end
    end

    // Shadow pipeline advance: E holds while busy and M takes bubbles behind it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_valid <= 1'b0;
            e_rs    <= '0;
            e_rt    <= '0;
            e_dst   <= '0;
            e_rw    <= 1'b0;
            e_m2r   <= 1'b0;
            m_dst   <= '0;
            m_rw    <= 1'b0;
            m_m2r   <= 1'b0;
            w_dst   <= '0;
            w_rw    <= 1'b0;
        end else begin
            w_dst <= m_dst;
            w_rw  <= m_rw;
            if (busy) begin
                m_dst <= '0;
                m_rw  <= 1'b0;
                m_m2r <= 1'b0;
            end else begin
                m_dst <= e_dst;
                m_rw  <= e_rw;
                m_m2r <= e_m2r;
                if (stall) begin
                    e_valid <= 1'b0;
                    e_rs    <= '0;
                    e_rt    <= '0;
                    e_dst   <= '0;
                    e_rw    <= 1'b0;
                    e_m2r   <= 1'b0;
                end else begin
                    // Control bits are qualified by id_valid so an empty ID
                    // slot can never look like a writer downstream.
                    e_valid <= id_valid;
                    e_rs    <= id_rs;
                    e_rt    <= id_rt;
                    e_dst   <= id_dst;
                    e_rw    <= id_valid && id_reg_write;
                    e_m2r   <= id_valid && id_mem_to_reg;
                end
            end
        end
    end

    // Multi-cycle countdown: loads on entry, decrements while busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
        end else if (enter_multi) begin
            cnt <= LAT_LOAD;
        end
    end

    // Saturating count of cycles in which the front end is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit_p.sv
// tb/tb_hazard_unit_p.sv - scoreboard bench for hazard_unit_p
module tb_hazard_unit_p;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic [4:0] id_dst;
    logic       id_reg_write;
    logic       id_mem_to_reg;
    logic       id_branch;
    logic       id_multi;
    logic       branch_taken;

    logic        stall_f, stall_d, stall_e, flush_d, flush_e, fwd_a_d, fwd_b_d, busy;
    logic [1:0]  fwd_a_e, fwd_b_e;
    logic [15:0] stall_cycles;

    logic        s_stall_f, s_stall_d, s_stall_e, s_flush_d, s_flush_e, s_fwd_a_d, s_fwd_b_d, s_busy;
    logic [1:0]  s_fwd_a_e, s_fwd_b_e;
    logic [3:0]  s_stall_cycles;

    int checks = 0;
    int errors = 0;
    int exp_total = 0;

    typedef struct {
        string      tag;
        logic       sf;
        logic       se;
        logic       fd;
        logic       fe;
        logic [1:0] fae;
        logic [1:0] fbe;
        logic       fad;
        logic       fbd;
        int         sc;
        int         sat;
    } exp_t;

    exp_t sb[$];

    hazard_unit_p #(.REG_AW(5), .MUL_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .id_multi(id_multi), .branch_taken(branch_taken),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .flush_d(flush_d),
        .flush_e(flush_e), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d),
        .fwd_b_d(fwd_b_d), .busy(busy), .stall_cycles(stall_cycles)
    );

    hazard_unit_p #(.REG_AW(5), .MUL_LAT(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .id_multi(id_multi), .branch_taken(branch_taken),
        .stall_f(s_stall_f), .stall_d(s_stall_d), .stall_e(s_stall_e), .flush_d(s_flush_d),
        .flush_e(s_flush_e), .fwd_a_e(s_fwd_a_e), .fwd_b_e(s_fwd_b_e), .fwd_a_d(s_fwd_a_d),
        .fwd_b_d(s_fwd_b_d), .busy(s_busy), .stall_cycles(s_stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic [4:0] dst,
                          input logic rw, input logic m2r, input logic br,
                          input logic mul, input logic tk);
        id_valid      = v;
        id_rs         = rs;
        id_rt         = rt;
        id_uses_rs    = urs;
        id_uses_rt    = urt;
        id_dst        = dst;
        id_reg_write  = rw;
        id_mem_to_reg = m2r;
        id_branch     = br;
        id_multi      = mul;
        branch_taken  = tk;
    endtask

    task automatic idle_id();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // hz: hazard stall (lu|br) expected, bz: multi-cycle busy expected.
    task automatic step(input string tag, input logic hz, input logic bz, input logic fd,
                        input logic fe, input logic [1:0] fae, input logic [1:0] fbe,
                        input logic fad, input logic fbd);
        exp_t e;
        e.tag = tag;
        e.sf  = hz | bz;
        e.se  = bz;
        e.fd  = fd;
        e.fe  = fe;
        e.fae = fae;
        e.fbe = fbe;
        e.fad = fad;
        e.fbd = fbd;
        e.sc  = exp_total;
        e.sat = (exp_total > 15) ? 15 : exp_total;
        sb.push_back(e);
        if (e.sf) exp_total++;
        @(posedge clk);
        #1;
    endtask

    task automatic zero_step(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    endtask

    // Compare both instances against the expectation pushed for this cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("%s.stall_f", e.tag), 32'(stall_f), 32'(e.sf));
            check($sformatf("%s.stall_d", e.tag), 32'(stall_d), 32'(e.sf));
            check($sformatf("%s.stall_e", e.tag), 32'(stall_e), 32'(e.se));
            check($sformatf("%s.busy", e.tag), 32'(busy), 32'(e.se));
            check($sformatf("%s.flush_d", e.tag), 32'(flush_d), 32'(e.fd));
            check($sformatf("%s.flush_e", e.tag), 32'(flush_e), 32'(e.fe));
            check($sformatf("%s.fwd_a_e", e.tag), 32'(fwd_a_e), 32'(e.fae));
            check($sformatf("%s.fwd_b_e", e.tag), 32'(fwd_b_e), 32'(e.fbe));
            check($sformatf("%s.fwd_a_d", e.tag), 32'(fwd_a_d), 32'(e.fad));
            check($sformatf("%s.fwd_b_d", e.tag), 32'(fwd_b_d), 32'(e.fbd));
            check($sformatf("%s.stall_cycles", e.tag), 32'(stall_cycles), 32'(e.sc));
            check($sformatf("%s.s_stall_f", e.tag), 32'(s_stall_f), 32'(e.sf));
            check($sformatf("%s.s_stall_d", e.tag), 32'(s_stall_d), 32'(e.sf));
            check($sformatf("%s.s_stall_e", e.tag), 32'(s_stall_e), 32'(e.se));
            check($sformatf("%s.s_busy", e.tag), 32'(s_busy), 32'(e.se));
            check($sformatf("%s.s_flush_d", e.tag), 32'(s_flush_d), 32'(e.fd));
            check($sformatf("%s.s_flush_e", e.tag), 32'(s_flush_e), 32'(e.fe));
            check($sformatf("%s.s_fwd_a_e", e.tag), 32'(s_fwd_a_e), 32'(e.fae));
            check($sformatf("%s.s_fwd_b_e", e.tag), 32'(s_fwd_b_e), 32'(e.fbe));
            check($sformatf("%s.s_fwd_a_d", e.tag), 32'(s_fwd_a_d), 32'(e.fad));
            check($sformatf("%s.s_fwd_b_d", e.tag), 32'(s_fwd_b_d), 32'(e.fbd));
            check($sformatf("%s.s_stall_cycles", e.tag), 32'(s_stall_cycles), 32'(e.sat));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_id();
        #1 rst = 1'b0;
        #1;
        check("reset.stall_f", 32'(stall_f), 32'd0);
        check("reset.stall_e", 32'(stall_e), 32'd0);
        check("reset.flush_d", 32'(flush_d), 32'd0);
        check("reset.flush_e", 32'(flush_e), 32'd0);
        check("reset.fwd_a_e", 32'(fwd_a_e), 32'd0);
        check("reset.fwd_b_e", 32'(fwd_b_e), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.stall_cycles", 32'(stall_cycles), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // load-use: load r3 in E, consumer of r3 in ID
        set_id(1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 1, 0, 0, 0);
        zero_step("lu.issue");
        set_id(1, 5'd3, 5'd2, 1, 1, 5'd6, 1, 0, 0, 0, 0);
        step("lu.stall", 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
        zero_step("lu.hold");
        idle_id();
        step("lu.wb_fwd", 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);

        // EX forwarding priority, then register 0 never forwards
        set_id(1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 0, 0, 0, 0);
        zero_step("pri.i1");
        zero_step("pri.i2");
        set_id(1, 5'd5, 5'd0, 1, 0, 5'd7, 1, 0, 0, 0, 0);
        step("pri.id_fwd", 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        idle_id();
        step("pri.mem", 0, 0, 0, 0, 2'b10, 2'b00, 0, 0);
        set_id(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 0, 0);
        zero_step("pri.z1");
        zero_step("pri.z2");
        set_id(1, 5'd0, 5'd0, 1, 1, 5'd7, 1, 0, 0, 0, 0);
        zero_step("pri.z_id");
        idle_id();
        zero_step("pri.z_ex");
        zero_step("pri.idle");
        zero_step("pri.idle");

        // ALU result -> branch: one stall then ID forward
        set_id(1, 5'd0, 5'd0, 0, 0, 5'd4, 1, 0, 0, 0, 0);
        zero_step("bra.alu");
        set_id(1, 5'd4, 5'd0, 1, 0, 5'd0, 0, 0, 1, 0, 0);
        step("bra.stall", 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
        step("bra.fwd", 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        idle_id();
        step("bra.ex_wb", 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
        zero_step("bra.idle");
        zero_step("bra.idle");

        // load -> taken branch: two stalls, no flush_d until clear
        set_id(1, 5'd0, 5'd0, 0, 0, 5'd4, 1, 1, 0, 0, 0);
        zero_step("brl.load");
        set_id(1, 5'd4, 5'd0, 1, 0, 5'd0, 0, 0, 1, 0, 1);
        step("brl.stall1", 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
        step("brl.stall2", 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
        step("brl.go", 0, 0, 1, 0, 2'b00, 2'b00, 0, 0);
        idle_id();
        zero_step("brl.idle");
        zero_step("brl.idle");
        zero_step("brl.idle");

        // taken branch without hazard
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd0, 0, 0, 1, 0, 1);
        step("tkn.flush", 0, 0, 1, 0, 2'b00, 2'b00, 0, 0);
        idle_id();
        zero_step("tkn.idle");
        zero_step("tkn.idle");
        zero_step("tkn.idle");

        // multi-cycle op with a dependent branch waiting behind it
        set_id(1, 5'd0, 5'd0, 0, 0, 5'd11, 1, 0, 0, 0, 0);
        zero_step("mul.x");
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd8, 1, 0, 0, 1, 0);
        zero_step("mul.issue");
        set_id(1, 5'd8, 5'd11, 1, 1, 5'd0, 0, 0, 1, 0, 1);
        step("mul.busy3", 1, 1, 0, 0, 2'b00, 2'b00, 0, 1);
        step("mul.busy2", 1, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        step("mul.busy1", 1, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        step("mul.br", 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
        step("mul.go", 0, 0, 1, 0, 2'b00, 2'b00, 1, 0);
        idle_id();
        step("mul.wb", 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
        zero_step("mul.idle");
        zero_step("mul.idle");

        // back-to-back multi ops push the narrow counter past saturation
        for (int i = 0; i < 5; i++) begin
            set_id(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0);
            zero_step("sat.issue");
            idle_id();
            step("sat.busy", 0, 1, 0, 0, 2'b00, 2'b00, 0, 0);
            step("sat.busy", 0, 1, 0, 0, 2'b00, 2'b00, 0, 0);
            step("sat.busy", 0, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        end
        zero_step("sat.idle");
        check("sat.final", 32'(s_stall_cycles), 32'd15);
        check("cnt.final", 32'(stall_cycles), 32'(exp_total));

        // asynchronous reset in the middle of a busy period
        set_id(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0);
        zero_step("rst.issue");
        idle_id();
        step("rst.busy", 0, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        #1 rst = 1'b0;
        #1;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.stall_e", 32'(stall_e), 32'd0);
        check("rst.stall_f", 32'(stall_f), 32'd0);
        check("rst.stall_cycles", 32'(stall_cycles), 32'd0);
        check("rst.s_stall_cycles", 32'(s_stall_cycles), 32'd0);
        exp_total = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        zero_step("rst.after");
        zero_step("rst.after");

        check("sb.empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit_p.md
# hazard_unit_p

Parametrised pipeline hazard controller for the 5-stage core. It keeps its own shadow copy of the destination and control information for the EX, MEM and WB stages, and from that it generates stall, flush and forwarding selects for both the ID-stage branch comparator and the EX-stage ALU operands. Beyond plain load-use detection, it adds branch-in-ID operand hazards, a multi-cycle EX operation with configurable latency, and a saturating stall-cycle counter. It sits beside the IF/ID and ID/EX pipeline registers and drives their enable and clear inputs.

## Interface
- REG_AW, 5, register-index width; index 0 is hard-wired zero and never matches.
- MUL_LAT, 4, EX latency in cycles of a multi-cycle op; must be ≥1, and 1 means no extra stall.
- CNT_W, 16, width of the stall-cycle counter.

- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- id_valid  in  1  instruction present in ID.
- id_rs, id_rt  in  REG_AW  ID source indices.
- id_uses_rs, id_uses_rt  in  1  source actually read.
- id_dst  in  REG_AW  ID destination (writeReg, already muxed by regDst).
- id_reg_write, id_mem_to_reg  in  1  ID regWrite / load.
- id_branch  in  1  ID branch needing rs/rt compare.
- id_multi  in  1  ID is a multi-cycle EX op.
- branch_taken  in  1  ID comparator result (valid only when id_branch).
- stall_f, stall_d  out  1  hold PC / hold IF/ID.
- stall_e  out  1  hold ID/EX (multi-cycle op busy).
- flush_d  out  1  clear IF/ID next edge.
- flush_e  out  1  insert bubble into ID/EX next edge.
- fwd_a_e, fwd_b_e  out  2  EX operand select: 00 register, 10 from MEM, 01 from WB.
- fwd_a_d, fwd_b_d  out  1  ID compare operand from MEM ALU result.
- busy  out  1  multi-cycle op in EX.
- stall_cycles  out  CNT_W  saturating count of cycles with stall_f=1.

## Operation
- **Shadow stages.** There are three stage slots: E, M and W.
  - Each slot holds {valid, rs, rt, dst, reg_write, mem_to_reg}; E also holds multi.
  - A bubble is the all-zero slot.
- **Load-use stall (lu).**
  - Condition: E.valid & E.mem_to_reg & E.dst≠0 & ((id_uses_rs & id_rs==E.dst) | (id_uses_rt & id_rt==E.dst)), gated by id_valid.
- **Branch stall (br).** Requires id_valid & id_branch, plus a source match (as above) against either:
  - E with E.reg_write, or
  - M with M.mem_to_reg.
- **Multi-cycle.**
  - When an op with multi=1 enters E, counter cnt loads MUL_LAT-1.
  - busy = (cnt≠0).
  - While busy, E holds and cnt decrements each cycle.
- **Output equations.**
  - stall_f = stall_d = lu | br | busy.
  - stall_e = busy.
  - flush_e = (lu | br) & !busy.
  - flush_d = id_valid & id_branch & branch_taken & !stall_d. Stall beats flush, and the branch re-evaluates next cycle.
- **Shadow advance on each edge.**
  - Not busy: W←M, M←E, E←(stall_d ? bubble : ID fields with valid=id_valid).
  - Busy: W←M, M←bubble, E holds.
- **EX forwarding (operand a; b is identical on rt).**
  - 10 if M.reg_write & M.dst≠0 & M.dst==E.rs.
  - Else 01 if W.reg_write & W.dst≠0 & W.dst==E.rs.
  - Else 00. MEM has priority over WB.
- **ID forwarding.** fwd_a_d = M.reg_write & !M.mem_to_reg & M.dst≠0 & M.dst==id_rs; fwd_b_d is identical on id_rt.
- **Stall counter.** Increments each cycle stall_f=1 and saturates at all-ones.

## Timing
- **Reset (rst=0, async).**
  - All slots are bubbles, cnt=0, stall_cycles=0.
  - All outputs are 0, since they are combinational from cleared state.
- **Output timing.** Stall, flush and fwd outputs are combinational from the current shadow state and ID inputs, valid in the same cycle. Shadow state, cnt and stall_cycles update on the edge.
- **Latencies.**
  - Load-use costs exactly 1 bubble.
  - ALU→branch costs 1 stall cycle.
  - Load→branch costs 2 stall cycles.
  - A multi-cycle op holds E for MUL_LAT-1 extra cycles. With MUL_LAT=1, busy never asserts.
- **Simultaneous events.** busy together with lu/br gives a stall without flush_e, because E is held, not bubbled.
- **Reset mid-operation.** Reset during busy clears cnt immediately; no stall persists after release.

## Test plan
- **Load-use.** E = load, dst=3; ID uses rs=3 → stall_f=stall_d=flush_e=1 for 1 cycle. Next cycle the load is in M, no stall, and fwd_a_e=01 the following cycle when the load is in W.
- **ALU forwarding priority.** M dst=5 reg_write, W dst=5 reg_write, E rs=5 → fwd_a_e=10. Same with dst=0 → fwd_a_e=00.
- **Branch hazards.**
  - ALU add dst=4 in E with beq rs=4 in ID → 1 stall cycle, then fwd_a_d=1.
  - Load dst=4 → 2 stall cycles, flush_d=0 throughout stall.
- **Multi-cycle op.** MUL_LAT=4, multi op enters E → busy=1 for 3 cycles, stall_e=1, M receives 3 bubbles. stall_cycles increments by 3.
- **Taken branch.** Taken branch with no hazard → flush_d=1 for one cycle. Same branch with lu stall → flush_d=0 until stall clears.
- **Reset and saturation.**
  - Async reset asserted mid-busy → busy=0 and stall_cycles=0 immediately.
  - CNT_W=4 with 20 stall cycles → stall_cycles=15.
